fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared widths, entry types and helpers for fetch_unit    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fetch_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            kill;
    } inflight_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with occupancy count and flush         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // a pop in the same cycle frees the slot a full-FIFO push needs
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : PC owner, credit-limited imem requester, decode buffer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_unit #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst
);

    import fetch_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    inflight_t        infl_q [DEPTH];
    inflight_t        infl_d [DEPTH];
    logic [PTR_W-1:0] infl_rd_q, infl_rd_d;
    logic [PTR_W-1:0] infl_wr_q, infl_wr_d;
    logic [CNT_W-1:0] infl_cnt_q, infl_cnt_d;

    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   credits_used;
    fetch_entry_t     buf_head, buf_push_data;
    inflight_t        infl_head;
    logic             issue, resp_take, buf_push, buf_pop;

    // killed fetches still hold credit until their response drains them
    assign credits_used   = {1'b0, infl_cnt_q} + {1'b0, buf_count};
    assign imem_req_valid = !rst && !redirect_valid && (credits_used < CREDIT_MAX);
    assign imem_req_addr  = pc_q;
    assign issue          = imem_req_valid && imem_req_ready;

    assign infl_head      = infl_q[infl_rd_q];
    assign resp_take      = imem_resp_valid && (infl_cnt_q != '0);
    assign buf_push       = resp_take && !infl_head.kill && !redirect_valid && !rst;
    assign buf_push_data  = '{pc: infl_head.pc, inst: imem_resp_data};

    assign if_valid       = (buf_count != '0) && !redirect_valid;
    assign buf_pop        = if_valid && if_ready;
    assign if_pc          = buf_head.pc;
    assign if_inst        = buf_head.inst;

    always_comb begin
        pc_d       = pc_q;
        infl_d     = infl_q;
        infl_rd_d  = infl_rd_q;
        infl_wr_d  = infl_wr_q;
        infl_cnt_d = infl_cnt_q;
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
            for (int i = 0; i < DEPTH; i++) begin
                infl_d[i].kill = 1'b1;
            end
        end else if (issue) begin
            pc_d              = pc_q + PC_STEP;
            infl_d[infl_wr_q] = '{pc: pc_q, kill: 1'b0};
            infl_wr_d         = infl_wr_q + 1'b1;
        end
        if (resp_take) begin
            infl_rd_d = infl_rd_q + 1'b1;
        end
        case ({issue, resp_take})
            2'b10:   infl_cnt_d = infl_cnt_q + 1'b1;
            2'b01:   infl_cnt_d = infl_cnt_q - 1'b1;
            default: infl_cnt_d = infl_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            infl_rd_q  <= '0;
            infl_wr_q  <= '0;
            infl_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            infl_rd_q  <= infl_rd_d;
            infl_wr_q  <= infl_wr_d;
            infl_cnt_q <= infl_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        infl_q <= infl_d;
    end

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data (buf_push_data),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    a_resp_has_inflight: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (infl_cnt_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : randomized and directed bench with queue-level model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int          XLEN     = 64;
    localparam int          DEPTH    = 2;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] PAT      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, redirect_valid, imem_req_ready, imem_resp_valid, if_ready;
    logic [63:0] redirect_pc, imem_req_addr, if_pc;
    logic        imem_req_valid, if_valid;
    logic [31:0] imem_resp_data, if_inst;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_inst         (if_inst)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; bit kill; }           m_infl_t;
    typedef struct { logic [63:0] pc; logic [31:0] inst; }  m_ent_t;
    typedef struct { logic [63:0] addr; int due; }          m_req_t;

    m_infl_t     m_infl[$];
    m_ent_t      m_buf[$];
    m_req_t      mem_q[$];
    logic [63:0] m_pc = RESET_PC;
    int          cyc = 0, errors = 0, checks = 0, lat = 1;
    string       tname;

    bit          cur_rst, cur_redir, cur_rdy, cur_drdy;
    logic [63:0] cur_rpc;
    bit          exp_req_valid, exp_if_valid;
    logic [63:0] exp_addr, exp_if_pc;
    logic [31:0] exp_if_inst;

    // Drive one cycle of inputs, let outputs settle, derive expectations from the model.
    task automatic drive(input bit r, input bit rd, input logic [63:0] rpc,
                         input bit rdy, input bit drdy);
        cur_rst = r; cur_redir = rd; cur_rpc = rpc; cur_rdy = rdy; cur_drdy = drdy;
        rst = r; redirect_valid = rd; redirect_pc = rpc;
        imem_req_ready = rdy; if_ready = drdy;
        imem_resp_valid = !r && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_resp_data  = imem_resp_valid ? (mem_q[0].addr[31:0] ^ PAT) : 32'($urandom);
        #1;
        exp_req_valid = !r && !rd && ((m_infl.size() + m_buf.size()) < DEPTH);
        exp_addr      = m_pc;
        exp_if_valid  = (m_buf.size() != 0) && !rd;
        exp_if_pc     = (m_buf.size() != 0) ? m_buf[0].pc   : '0;
        exp_if_inst   = (m_buf.size() != 0) ? m_buf[0].inst : '0;
    endtask

    // Advance memory and reference model across the rising edge.
    task automatic tick();
        m_infl_t h;
        int      d;
        if (cur_rst) begin
            mem_q.delete();
        end else begin
            if (imem_resp_valid) void'(mem_q.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                d = cyc + lat;
                if (mem_q.size() > 0 && mem_q[$].due >= d) d = mem_q[$].due + 1;
                mem_q.push_back('{addr: imem_req_addr, due: d});
            end
        end
        if (cur_rst) begin
            m_pc = RESET_PC; m_infl.delete(); m_buf.delete();
        end else if (cur_redir) begin
            if (imem_resp_valid && m_infl.size() > 0) void'(m_infl.pop_front());
            foreach (m_infl[i]) m_infl[i].kill = 1'b1;
            m_buf.delete();
            m_pc = {cur_rpc[63:2], 2'b00};
        end else begin
            if (exp_if_valid && cur_drdy) void'(m_buf.pop_front());
            if (imem_resp_valid && m_infl.size() > 0) begin
                h = m_infl.pop_front();
                if (!h.kill) m_buf.push_back('{pc: h.pc, inst: imem_resp_data});
            end
            if (exp_req_valid && cur_rdy) begin
                m_infl.push_back('{pc: m_pc, kill: 1'b0});
                m_pc = m_pc + 64'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        tname = "reset";
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, '0, 1'b1, 1'b1);
            checks++;
            if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset req_valid during rst got=%b exp=0", imem_req_valid); end
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_req_addr !== RESET_PC) begin errors++; $display("FAIL reset req_addr got=%h exp=%h", imem_req_addr, RESET_PC); end
        checks++;
        if (if_valid !== 1'b0) begin errors++; $display("FAIL reset if_valid got=%b exp=0", if_valid); end
        checks++;
        if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset req_valid after release got=%b exp=1", imem_req_valid); end
        tick();
    endtask

    task automatic test_stream();
        tname = "stream"; lat = 1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
            checks++;
            if ({imem_req_valid, imem_req_addr} !== {exp_req_valid, exp_addr}) begin errors++; $display("FAIL %s req cyc=%0d got=%b/%h exp=%b/%h", tname, cyc, imem_req_valid, imem_req_addr, exp_req_valid, exp_addr); end
            checks++;
            if (if_valid !== exp_if_valid) begin errors++; $display("FAIL %s if_valid cyc=%0d got=%b exp=%b", tname, cyc, if_valid, exp_if_valid); end
            if (exp_if_valid) begin
                checks++;
                if ({if_pc, if_inst} !== {exp_if_pc, exp_if_inst}) begin errors++; $display("FAIL %s if_pc/inst cyc=%0d got=%h/%h exp=%h/%h", tname, cyc, if_pc, if_inst, exp_if_pc, exp_if_inst); end
                checks++;
                if (if_inst !== (if_pc[31:0] ^ PAT)) begin errors++; $display("FAIL %s inst_for_pc got=%h exp=%h", tname, if_inst, if_pc[31:0] ^ PAT); end
            end
            tick();
        end
    endtask

    task automatic test_decode_stall();
        int n_iss;
        tname = "decode_stall"; lat = 1; n_iss = 0;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
            checks++;
            if ({imem_req_valid, imem_req_addr} !== {exp_req_valid, exp_addr}) begin errors++; $display("FAIL %s req cyc=%0d got=%b/%h exp=%b/%h", tname, cyc, imem_req_valid, imem_req_addr, exp_req_valid, exp_addr); end
            checks++;
            if (if_valid !== exp_if_valid) begin errors++; $display("FAIL %s if_valid cyc=%0d got=%b exp=%b", tname, cyc, if_valid, exp_if_valid); end
            if (imem_req_valid) n_iss++;
            tick();
        end
        checks++;
        if (n_iss !== 2) begin errors++; $display("FAIL %s issued_count got=%0d exp=2", tname, n_iss); end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if ({imem_req_valid, if_valid, if_pc} !== {1'b0, 1'b1, 64'h0}) begin errors++; $display("FAIL %s pop_cycle got=%b/%b/%h exp=0/1/0", tname, imem_req_valid, if_valid, if_pc); end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8}) begin errors++; $display("FAIL %s refill_req got=%b/%h exp=1/8", tname, imem_req_valid, imem_req_addr); end
        checks++;
        if ({if_valid, if_pc} !== {exp_if_valid, exp_if_pc}) begin errors++; $display("FAIL %s if_after_pop got=%b/%h exp=%b/%h", tname, if_valid, if_pc, exp_if_valid, exp_if_pc); end
        tick();
    endtask

    task automatic test_req_stall();
        int stalls;
        bit rdy;
        tname = "req_stall"; lat = 1; stalls = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            rdy = !(m_pc == 64'h8 && stalls < 3);
            drive(1'b0, 1'b0, '0, rdy, 1'b1);
            checks++;
            if ({imem_req_valid, imem_req_addr} !== {exp_req_valid, exp_addr}) begin errors++; $display("FAIL %s req cyc=%0d got=%b/%h exp=%b/%h", tname, cyc, imem_req_valid, imem_req_addr, exp_req_valid, exp_addr); end
            checks++;
            if (if_valid !== exp_if_valid) begin errors++; $display("FAIL %s if_valid cyc=%0d got=%b exp=%b", tname, cyc, if_valid, exp_if_valid); end
            if (exp_if_valid) begin
                checks++;
                if ({if_pc, if_inst} !== {exp_if_pc, exp_if_inst}) begin errors++; $display("FAIL %s if_pc/inst cyc=%0d got=%h/%h exp=%h/%h", tname, cyc, if_pc, if_inst, exp_if_pc, exp_if_inst); end
            end
            if (!rdy && exp_req_valid) begin
                stalls++;
                checks++;
                if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8}) begin errors++; $display("FAIL %s held_addr got=%b/%h exp=1/8", tname, imem_req_valid, imem_req_addr); end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        bit hit, seen;
        tname = "redirect"; lat = 3; hit = 0; seen = 0;
        apply_reset();
        for (int i = 0; i < 30 && !hit; i++) begin
            if (m_infl.size() == 2 && m_infl[1].pc == 64'hC) hit = 1;
            else begin drive(1'b0, 1'b0, '0, 1'b1, 1'b1); tick(); end
        end
        if (!hit) begin errors++; $display("FAIL %s setup timeout got=no_outstanding exp=8,C outstanding", tname); end
        drive(1'b0, 1'b1, 64'h100, 1'b1, 1'b1);
        checks++;
        if ({imem_req_valid, if_valid} !== 2'b00) begin errors++; $display("FAIL %s redirect_cycle req/if got=%b/%b exp=0/0", tname, imem_req_valid, if_valid); end
        tick();
        for (int i = 0; i < 30 && !seen; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
            checks++;
            if ({imem_req_valid, imem_req_addr} !== {exp_req_valid, exp_addr}) begin errors++; $display("FAIL %s req cyc=%0d got=%b/%h exp=%b/%h", tname, cyc, imem_req_valid, imem_req_addr, exp_req_valid, exp_addr); end
            checks++;
            if (if_valid !== exp_if_valid) begin errors++; $display("FAIL %s if_valid cyc=%0d got=%b exp=%b", tname, cyc, if_valid, exp_if_valid); end
            if (if_valid) begin
                seen = 1;
                checks++;
                if ({if_pc, if_inst} !== {64'h100, 32'h100 ^ PAT}) begin errors++; $display("FAIL %s first_after got=%h/%h exp=100/%h", tname, if_pc, if_inst, 32'h100 ^ PAT); end
            end
            tick();
        end
        if (!seen) begin errors++; $display("FAIL %s timeout got=no if_valid exp=if_pc 100", tname); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        tname = "back_to_back"; lat = 3; seen = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0, '0, 1'b1, 1'b1); tick(); end
        drive(1'b0, 1'b1, 64'h203, 1'b1, 1'b1);
        checks++;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL %s redirect1 req_valid got=%b exp=0", tname, imem_req_valid); end
        tick();
        drive(1'b0, 1'b1, 64'h300, 1'b1, 1'b1);
        checks++;
        if ({imem_req_valid, if_valid} !== 2'b00) begin errors++; $display("FAIL %s redirect2 req/if got=%b/%b exp=0/0", tname, imem_req_valid, if_valid); end
        tick();
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (i == 0) begin
                checks++;
                if (imem_req_addr !== 64'h300) begin errors++; $display("FAIL %s next_addr got=%h exp=300", tname, imem_req_addr); end
            end
            checks++;
            if ({imem_req_valid, imem_req_addr} !== {exp_req_valid, exp_addr}) begin errors++; $display("FAIL %s req cyc=%0d got=%b/%h exp=%b/%h", tname, cyc, imem_req_valid, imem_req_addr, exp_req_valid, exp_addr); end
            checks++;
            if (if_valid !== exp_if_valid) begin errors++; $display("FAIL %s if_valid cyc=%0d got=%b exp=%b", tname, cyc, if_valid, exp_if_valid); end
            if (if_valid && !seen) begin
                seen = 1;
                checks++;
                if (if_pc !== 64'h300) begin errors++; $display("FAIL %s first_pc got=%h exp=300", tname, if_pc); end
            end
            tick();
        end
        if (!seen) begin errors++; $display("FAIL %s timeout got=no if_valid exp=if_pc 300", tname); end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        tname = "reset_mid"; lat = 1; seen = 0;
        apply_reset();
        for (int i = 0; i < 10 && m_buf.size() < DEPTH; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0); tick();
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (if_valid !== 1'b1) begin errors++; $display("FAIL %s full_if_valid got=%b exp=1", tname, if_valid); end
        tick();
        apply_reset();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if ({if_valid, imem_req_addr} !== {1'b0, RESET_PC}) begin errors++; $display("FAIL %s after_rst got=%b/%h exp=0/%h", tname, if_valid, imem_req_addr, RESET_PC); end
        tick();
        for (int i = 0; i < 10 && !seen; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (if_valid) begin
                seen = 1;
                checks++;
                if (if_pc !== RESET_PC) begin errors++; $display("FAIL %s first_pc got=%h exp=%h", tname, if_pc, RESET_PC); end
            end
            tick();
        end
        if (!seen) begin errors++; $display("FAIL %s timeout got=no if_valid exp=if_pc %h", tname, RESET_PC); end
    endtask

    task automatic test_wrap();
        tname = "wrap"; lat = 2;
        drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (i == 0) begin
                checks++;
                if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL %s aligned_addr got=%h exp=fffffffffffffffc", tname, imem_req_addr); end
            end
            checks++;
            if ({imem_req_valid, imem_req_addr} !== {exp_req_valid, exp_addr}) begin errors++; $display("FAIL %s req cyc=%0d got=%b/%h exp=%b/%h", tname, cyc, imem_req_valid, imem_req_addr, exp_req_valid, exp_addr); end
            checks++;
            if (if_valid !== exp_if_valid) begin errors++; $display("FAIL %s if_valid cyc=%0d got=%b exp=%b", tname, cyc, if_valid, exp_if_valid); end
            if (exp_if_valid) begin
                checks++;
                if ({if_pc, if_inst} !== {exp_if_pc, exp_if_inst}) begin errors++; $display("FAIL %s if_pc/inst cyc=%0d got=%h/%h exp=%h/%h", tname, cyc, if_pc, if_inst, exp_if_pc, exp_if_inst); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit r, rd;
        tname = "random";
        for (int i = 0; i < 1500; i++) begin
            lat = int'($urandom_range(1, 4));
            r   = ($urandom_range(0, 99) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            drive(r, rd, {32'($urandom), 32'($urandom)},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            checks++;
            if (imem_req_valid !== exp_req_valid) begin errors++; $display("FAIL %s req_valid cyc=%0d got=%b exp=%b", tname, cyc, imem_req_valid, exp_req_valid); end
            if (!cur_rst) begin
                checks++;
                if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL %s req_addr cyc=%0d got=%h exp=%h", tname, cyc, imem_req_addr, exp_addr); end
                checks++;
                if (if_valid !== exp_if_valid) begin errors++; $display("FAIL %s if_valid cyc=%0d got=%b exp=%b", tname, cyc, if_valid, exp_if_valid); end
                if (exp_if_valid) begin
                    checks++;
                    if ({if_pc, if_inst} !== {exp_if_pc, exp_if_inst}) begin errors++; $display("FAIL %s if_pc/inst cyc=%0d got=%h/%h exp=%h/%h", tname, cyc, if_pc, if_inst, exp_if_pc, exp_if_inst); end
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_decode_stall();
        test_req_stall();
        test_redirect();
        test_back_to_back();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
